// File: rtl/axi_isolate_drain.sv
// rtl/axi_isolate_drain.sv - AXI isolation sequencer: blocks new AW/AR, drains in-flight bursts, then isolates.
module axi_isolate_drain #(
  parameter int MAX_WR_OUT = 16,
  parameter int MAX_RD_OUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic isolate_req_i,
  output logic isolate_o,
  output logic isolated_o,
  output logic protocol_err_o,
  input  logic slv_aw_valid_i,
  output logic slv_aw_ready_o,
  input  logic slv_ar_valid_i,
  output logic slv_ar_ready_o,
  input  logic slv_w_valid_i,
  input  logic slv_w_last_i,
  output logic slv_w_ready_o,
  output logic mst_aw_valid_o,
  input  logic mst_aw_ready_i,
  output logic mst_ar_valid_o,
  input  logic mst_ar_ready_i,
  output logic mst_w_valid_o,
  input  logic mst_w_ready_i,
  input  logic mst_b_valid_i,
  input  logic mst_b_ready_i,
  input  logic mst_r_valid_i,
  input  logic mst_r_last_i,
  input  logic mst_r_ready_i
);
  localparam int WW = $clog2(MAX_WR_OUT + 1);
  localparam int RW = $clog2(MAX_RD_OUT + 1);
  localparam logic [WW-1:0] WR_MAX = WW'(MAX_WR_OUT);
  localparam logic [WW-1:0] WR_ONE = WW'(1);
  localparam logic [RW-1:0] RD_MAX = RW'(MAX_RD_OUT);
  localparam logic [RW-1:0] RD_ONE = RW'(1);

  typedef enum logic [1:0] {RUN, DRAIN, ISOLATED} state_t;

  state_t state_q, state_d;
  logic [WW-1:0] wr_cnt, wr_cnt_nxt, w_owed, w_owed_nxt;
  logic [RW-1:0] rd_cnt, rd_cnt_nxt;
  logic aw_stall, aw_stall_nxt, ar_stall, ar_stall_nxt;
  logic wr_uf, rd_uf, w_uf;
  logic aw_en, ar_en, w_en;
  logic aw_hs, ar_hs, w_last_hs, b_hs, r_last_hs;
  logic iso_q, err_q;

  assign aw_hs     = mst_aw_valid_o & mst_aw_ready_i;
  assign ar_hs     = mst_ar_valid_o & mst_ar_ready_i;
  assign w_last_hs = mst_w_valid_o & mst_w_ready_i & slv_w_last_i;
  assign b_hs      = mst_b_valid_i & mst_b_ready_i;
  assign r_last_hs = mst_r_valid_i & mst_r_ready_i & mst_r_last_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Drain completion looks at next-cycle counts so isolation follows the final response by one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (isolate_req_i) state_d = DRAIN;
      DRAIN: begin
        if (!isolate_req_i)
          state_d = RUN;
        else if (wr_cnt_nxt == '0 && rd_cnt_nxt == '0 && w_owed_nxt == '0 &&
                 !aw_stall_nxt && !ar_stall_nxt)
          state_d = ISOLATED;
      end
      ISOLATED: if (!isolate_req_i) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // Gating enables use registered state only; a stalled valid keeps its channel open.
  always_comb begin
    aw_en          = (state_q == RUN && wr_cnt < WR_MAX) || aw_stall;
    ar_en          = (state_q == RUN && rd_cnt < RD_MAX) || ar_stall;
    w_en           = (state_q == RUN) || (w_owed != '0);
    mst_aw_valid_o = slv_aw_valid_i & aw_en;
    slv_aw_ready_o = mst_aw_ready_i & aw_en;
    mst_ar_valid_o = slv_ar_valid_i & ar_en;
    slv_ar_ready_o = mst_ar_ready_i & ar_en;
    mst_w_valid_o  = slv_w_valid_i & w_en;
    slv_w_ready_o  = mst_w_ready_i & w_en;
    isolate_o      = iso_q;
    isolated_o     = iso_q;
    protocol_err_o = err_q;
  end

  always_comb begin
    wr_cnt_nxt = wr_cnt;
    rd_cnt_nxt = rd_cnt;
    w_owed_nxt = w_owed;
    wr_uf      = 1'b0;
    rd_uf      = 1'b0;
    w_uf       = 1'b0;
    if (aw_hs && !b_hs)
      wr_cnt_nxt = wr_cnt + WR_ONE;
    else if (b_hs && !aw_hs) begin
      if (wr_cnt == '0) wr_uf = 1'b1;
      else              wr_cnt_nxt = wr_cnt - WR_ONE;
    end
    if (ar_hs && !r_last_hs)
      rd_cnt_nxt = rd_cnt + RD_ONE;
    else if (r_last_hs && !ar_hs) begin
      if (rd_cnt == '0) rd_uf = 1'b1;
      else              rd_cnt_nxt = rd_cnt - RD_ONE;
    end
    // W may lead AW while running, so an unmatched W-last is only an error once draining.
    if (aw_hs && !w_last_hs) begin
      if (w_owed != WR_MAX) w_owed_nxt = w_owed + WR_ONE;
    end else if (w_last_hs && !aw_hs) begin
      if (w_owed == '0) w_uf = (state_q != RUN);
      else              w_owed_nxt = w_owed - WR_ONE;
    end
    aw_stall_nxt = mst_aw_valid_o ? !mst_aw_ready_i : aw_stall;
    ar_stall_nxt = mst_ar_valid_o ? !mst_ar_ready_i : ar_stall;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      w_owed   <= '0;
      aw_stall <= 1'b0;
      ar_stall <= 1'b0;
      iso_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_cnt   <= wr_cnt_nxt;
      rd_cnt   <= rd_cnt_nxt;
      w_owed   <= w_owed_nxt;
      aw_stall <= aw_stall_nxt;
      ar_stall <= ar_stall_nxt;
      iso_q    <= (state_d == ISOLATED);
      if (wr_uf || rd_uf || w_uf) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axi_isolate_drain.sv
// tb/tb_axi_isolate_drain.sv - directed table and sequence bench for axi_isolate_drain.
module tb_axi_isolate_drain;
  logic clk, rst_i, isolate_req_i;
  logic isolate_o, isolated_o, protocol_err_o;
  logic slv_aw_valid_i, slv_aw_ready_o, slv_ar_valid_i, slv_ar_ready_o;
  logic slv_w_valid_i, slv_w_last_i, slv_w_ready_o;
  logic mst_aw_valid_o, mst_aw_ready_i, mst_ar_valid_o, mst_ar_ready_i;
  logic mst_w_valid_o, mst_w_ready_i;
  logic mst_b_valid_i, mst_b_ready_i, mst_r_valid_i, mst_r_last_i, mst_r_ready_i;

  int n_pass = 0;
  int n_tot  = 0;
  int okcnt;
  bit in_abort = 1'b0;
  bit abort_seen = 1'b0;

  axi_isolate_drain #(.MAX_WR_OUT(4), .MAX_RD_OUT(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .isolate_req_i(isolate_req_i),
    .isolate_o(isolate_o), .isolated_o(isolated_o), .protocol_err_o(protocol_err_o),
    .slv_aw_valid_i(slv_aw_valid_i), .slv_aw_ready_o(slv_aw_ready_o),
    .slv_ar_valid_i(slv_ar_valid_i), .slv_ar_ready_o(slv_ar_ready_o),
    .slv_w_valid_i(slv_w_valid_i), .slv_w_last_i(slv_w_last_i), .slv_w_ready_o(slv_w_ready_o),
    .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_ready_i(mst_aw_ready_i),
    .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_ready_i(mst_ar_ready_i),
    .mst_w_valid_o(mst_w_valid_o), .mst_w_ready_i(mst_w_ready_i),
    .mst_b_valid_i(mst_b_valid_i), .mst_b_ready_i(mst_b_ready_i),
    .mst_r_valid_i(mst_r_valid_i), .mst_r_last_i(mst_r_last_i), .mst_r_ready_i(mst_r_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (in_abort && isolated_o) abort_seen = 1'b1;

  typedef struct {
    logic aw_v, aw_r, ar_v, ar_r, w_v, w_r;
    logic [5:0] exp_run;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    slv_aw_valid_i = 0; slv_ar_valid_i = 0; slv_w_valid_i = 0; slv_w_last_i = 0;
    mst_aw_ready_i = 0; mst_ar_ready_i = 0; mst_w_ready_i = 0;
    mst_b_valid_i = 0; mst_b_ready_i = 0; mst_r_valid_i = 0; mst_r_last_i = 0; mst_r_ready_i = 0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    clear_in();
    isolate_req_i = 1'b0;
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic apply_tbl(input bit iso);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      slv_aw_valid_i = tbl[i].aw_v; mst_aw_ready_i = tbl[i].aw_r;
      slv_ar_valid_i = tbl[i].ar_v; mst_ar_ready_i = tbl[i].ar_r;
      slv_w_valid_i  = tbl[i].w_v;  mst_w_ready_i  = tbl[i].w_r;
      #1;
      chk($sformatf("tbl_%s_%0d", iso ? "iso" : "run", i),
          32'({mst_aw_valid_o, slv_aw_ready_o, mst_ar_valid_o, slv_ar_ready_o, mst_w_valid_o, slv_w_ready_o}),
          iso ? 32'd0 : 32'(tbl[i].exp_run));
      #1 clear_in();
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b100000};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b010000};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b001100};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000011};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'b111111};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'b100101};

    clear_in();
    isolate_req_i = 1'b0;
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    #1;
    chk("reset_outputs", 32'({isolate_o, isolated_o, protocol_err_o}), 32'd0);
    apply_tbl(1'b0);

    // idle isolate
    tick(); isolate_req_i = 1'b1;
    tick(); chk("idle_cycle1", 32'(isolated_o), 32'd0);
    tick(); chk("idle_cycle2", 32'({isolate_o, isolated_o}), 32'd3);
    apply_tbl(1'b1);
    tick(); isolate_req_i = 1'b0;
    #1 chk("idle_release_same", 32'({isolate_o, isolated_o}), 32'd3);
    tick(); chk("idle_release_next", 32'({isolate_o, isolated_o}), 32'd0);

    // drain with traffic: 3 AW, 2 AR outstanding
    slv_aw_valid_i = 1; mst_aw_ready_i = 1; slv_ar_valid_i = 1; mst_ar_ready_i = 1;
    tick(); tick(); slv_ar_valid_i = 0;
    tick(); slv_aw_valid_i = 0; isolate_req_i = 1'b1;
    tick();
    slv_aw_valid_i = 1; slv_ar_valid_i = 1;
    #1 chk("drain_new_blocked", 32'({mst_aw_valid_o, slv_aw_ready_o, mst_ar_valid_o, slv_ar_ready_o}), 32'd0);
    clear_in();
    slv_w_valid_i = 1; mst_w_ready_i = 1;
    okcnt = 0;
    for (int i = 0; i < 12; i++) begin
      slv_w_last_i = (i % 4 == 3);
      #1 if (mst_w_valid_o && slv_w_ready_o) okcnt++;
      tick();
    end
    chk("drain_w_beats", 32'(okcnt), 32'd12);
    slv_w_last_i = 0;
    #1 chk("drain_w_extra_blocked", 32'({mst_w_valid_o, slv_w_ready_o}), 32'd0);
    clear_in();
    mst_b_valid_i = 1; mst_b_ready_i = 1;
    tick(); tick(); mst_b_valid_i = 0;
    mst_r_valid_i = 1; mst_r_ready_i = 1; mst_r_last_i = 1;
    tick(); mst_r_valid_i = 0; mst_b_valid_i = 1;
    tick(); mst_b_valid_i = 0;
    chk("drain_not_yet", 32'(isolated_o), 32'd0);
    mst_r_valid_i = 1;
    tick(); clear_in();
    chk("drain_iso_1cyc", 32'({isolate_o, isolated_o}), 32'd3);
    isolate_req_i = 1'b0;
    tick(); chk("drain_release", 32'(isolated_o), 32'd0);

    // stalled AW at request
    slv_aw_valid_i = 1; mst_aw_ready_i = 0;
    tick(); isolate_req_i = 1'b1;
    tick(); chk("stall_valid_held", 32'(mst_aw_valid_o), 32'd1);
    tick(); chk("stall_valid_held2", 32'({mst_aw_valid_o, isolated_o}), 32'd2);
    mst_aw_ready_i = 1;
    #1 chk("stall_ready_pass", 32'(slv_aw_ready_o), 32'd1);
    tick(); mst_aw_ready_i = 0;
    #1 chk("stall_after_hs_blocked", 32'(mst_aw_valid_o), 32'd0);
    slv_aw_valid_i = 0;
    tick(); chk("stall_wait_w", 32'(isolated_o), 32'd0);
    slv_w_valid_i = 1; mst_w_ready_i = 1; slv_w_last_i = 1;
    #1 chk("stall_w_owed_pass", 32'(slv_w_ready_o), 32'd1);
    tick(); clear_in();
    tick(); chk("stall_wait_b", 32'(isolated_o), 32'd0);
    mst_b_valid_i = 1; mst_b_ready_i = 1;
    tick(); clear_in();
    chk("stall_iso_after_b", 32'(isolated_o), 32'd1);
    isolate_req_i = 1'b0;
    tick();

    // outstanding limit (MAX_WR_OUT=4)
    slv_aw_valid_i = 1; mst_aw_ready_i = 1;
    okcnt = 0;
    for (int i = 0; i < 4; i++) begin
      #1 if (slv_aw_ready_o) okcnt++;
      tick();
    end
    chk("lim_4_accepted", 32'(okcnt), 32'd4);
    #1 chk("lim_5th_blocked", 32'({mst_aw_valid_o, slv_aw_ready_o}), 32'd0);
    slv_aw_valid_i = 0; mst_b_valid_i = 1; mst_b_ready_i = 1;
    tick(); mst_b_valid_i = 0; slv_aw_valid_i = 1;
    #1 chk("lim_after_b", 32'(slv_aw_ready_o), 32'd1);
    tick(); chk("lim_full_again", 32'(slv_aw_ready_o), 32'd0);
    slv_aw_valid_i = 0; mst_b_valid_i = 1;
    tick(); slv_aw_valid_i = 1;
    tick(); mst_b_valid_i = 0;
    chk("lim_same_cycle_held", 32'(slv_aw_ready_o), 32'd1);
    tick(); chk("lim_same_cycle_full", 32'(slv_aw_ready_o), 32'd0);
    slv_aw_valid_i = 0;

    // reset mid-burst
    rst_i = 1'b1;
    #1 chk("rst_mid_burst", 32'(slv_aw_ready_o), 32'd1);
    tick(); rst_i = 1'b0; clear_in();
    isolate_req_i = 1'b1;
    tick(); tick();
    chk("rst_counts_zero", 32'(isolated_o), 32'd1);
    isolate_req_i = 1'b0;
    tick();

    // abort drain with wr_cnt=2
    in_abort = 1'b1;
    slv_aw_valid_i = 1; mst_aw_ready_i = 1;
    tick(); tick(); slv_aw_valid_i = 0; isolate_req_i = 1'b1;
    tick(); slv_aw_valid_i = 1;
    #1 chk("abort_blocked", 32'(slv_aw_ready_o), 32'd0);
    isolate_req_i = 1'b0;
    tick(); chk("abort_resume", 32'(slv_aw_ready_o), 32'd1);
    tick(); slv_aw_valid_i = 0;
    tick(); in_abort = 1'b0;
    chk("abort_never_iso", 32'(abort_seen), 32'd0);
    do_reset();

    // protocol error: B with wr_cnt=0
    mst_b_valid_i = 1; mst_b_ready_i = 1;
    tick(); clear_in();
    chk("perr_set", 32'(protocol_err_o), 32'd1);
    tick(); tick();
    chk("perr_sticky", 32'(protocol_err_o), 32'd1);
    slv_aw_valid_i = 1; mst_aw_ready_i = 1;
    okcnt = 0;
    for (int i = 0; i < 4; i++) begin
      #1 if (slv_aw_ready_o) okcnt++;
      tick();
    end
    chk("perr_cnt_held_zero", 32'(okcnt), 32'd4);
    #1 chk("perr_cnt_full", 32'(slv_aw_ready_o), 32'd0);
    chk("perr_still_set", 32'(protocol_err_o), 32'd1);
    do_reset();
    chk("perr_cleared", 32'(protocol_err_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
